// File: rtl/vga_pkg.sv
// Shared board geometry, colour codes and arbiter state for the Tetris VGA board.
package vga_pkg;
    localparam int BOARD_COLS  = 10;
    localparam int BOARD_ROWS  = 20;
    localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;
    localparam int BOARD_AW    = 8;
    localparam int BOARD_CW    = 3;

    typedef enum logic [BOARD_CW-1:0] {
        COL_EMPTY  = 3'd0,
        COL_CYAN   = 3'd1,
        COL_BLUE   = 3'd2,
        COL_ORANGE = 3'd3,
        COL_YELLOW = 3'd4,
        COL_GREEN  = 3'd5,
        COL_PURPLE = 3'd6,
        COL_RED    = 3'd7
    } colour_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/board_ram.sv
// Single-port board-cell RAM, 1-cycle read. Out-of-range writes are dropped
// and out-of-range reads return 0.
module board_ram #(
    parameter int CELLS = 200,
    parameter int AW    = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [CW-1:0] wdata,
    output logic [CW-1:0] rdata
);
    logic [CW-1:0] mem [CELLS];
    logic          in_range;

    assign in_range = int'(addr) < CELLS;

    always_ff @(posedge clk) begin
        if (we && in_range) mem[addr] <= wdata;
        rdata <= in_range ? mem[addr] : '0;
    end
endmodule

// File: rtl/vga_board_arbiter.sv
// Board memory arbiter: scanout reads first, then the clear sequencer, then
// game accesses. Writes may be confined to vertical blanking.
module vga_board_arbiter
    import vga_pkg::*;
#(
    parameter int COLS           = BOARD_COLS,
    parameter int ROWS           = BOARD_ROWS,
    parameter int CELLS          = COLS * ROWS,
    parameter int AW             = BOARD_AW,
    parameter int CW             = BOARD_CW,
    parameter bit WR_VBLANK_ONLY = 1'b1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          vblank,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic [CW-1:0] scan_rdata,
    output logic          scan_valid,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [CW-1:0] g_wdata,
    output logic          g_gnt,
    output logic [CW-1:0] g_rdata,
    output logic          g_rvalid,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done
);
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

    arb_state_t    state, state_nxt;
    logic [AW-1:0] cnt;
    logic          clr_wr;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] ram_wdata;
    logic [CW-1:0] ram_rdata;
    logic [CW-1:0] scan_hold, g_hold;

    board_ram #(.CELLS(CELLS), .AW(AW), .CW(CW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_wr    = 1'b0;
        g_gnt     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = g_addr;
        ram_wdata = g_wdata;
        case (state)
            ST_IDLE: begin
                g_gnt = !clr && g_req && !scan_req && (!g_we || !WR_VBLANK_ONLY || vblank);
                if (clear_start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_wr = !clr && !scan_req && (vblank || !WR_VBLANK_ONLY);
                if (clr_wr && cnt == LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Port mux follows the same priority as the grant logic above.
        if (scan_req) begin
            ram_addr = scan_addr;
        end else if (state == ST_CLEAR) begin
            ram_addr  = cnt;
            ram_wdata = CW'(COL_EMPTY);
            ram_we    = clr_wr;
        end else begin
            ram_we = g_gnt && g_we;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt        <= '0;
            scan_valid <= 1'b0;
            g_rvalid   <= 1'b0;
            scan_hold  <= '0;
            g_hold     <= '0;
            clear_done <= 1'b0;
        end else begin
            scan_valid <= scan_req;
            g_rvalid   <= g_gnt && !g_we;
            if (scan_valid) scan_hold <= ram_rdata;
            if (g_rvalid)   g_hold    <= ram_rdata;
            clear_done <= clr_wr && (cnt == LAST);
            if (clr_wr) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // RAM output is live only in the cycle after a read; otherwise replay the last value.
    assign scan_rdata = scan_valid ? ram_rdata : scan_hold;
    assign g_rdata    = g_rvalid   ? ram_rdata : g_hold;
    assign clear_busy = (state == ST_CLEAR);
endmodule

// File: tb/tb_vga_board_arbiter.sv
// Randomized bench for vga_board_arbiter against a cell-array reference model.
module tb_vga_board_arbiter;
    logic       clk = 1'b0;
    logic       clr, vblank, scan_req, g_req, g_we, clear_start;
    logic [7:0] scan_addr, g_addr;
    logic [2:0] g_wdata;
    logic [2:0] scan_rdata, g_rdata;
    logic       scan_valid, g_gnt, g_rvalid, clear_busy, clear_done;

    int n_cmp = 0;
    int n_bad = 0;

    vga_board_arbiter dut (
        .clk(clk), .clr(clr), .vblank(vblank),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_rdata(scan_rdata), .scan_valid(scan_valid),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rdata(g_rdata), .g_rvalid(g_rvalid),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // Reference model: board contents, clear progress, expected registered outputs.
    int   mem_m [200];
    bit   m_clear = 0;
    int   m_cidx  = 0;
    bit   have_exp = 0;
    logic e_sv, e_gv, e_busy, e_done;
    int   e_srd, e_grd;
    int   busy_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rd(input int a);
        return (a < 200) ? mem_m[a] : 0;
    endfunction

    task automatic cyc(input bit i_clr, input bit i_vb, input bit i_sreq, input int i_sa,
                       input bit i_greq, input bit i_gwe, input int i_ga, input int i_gwd,
                       input bit i_cs);
        bit g;
        @(negedge clk);
        if (have_exp) begin
            chk("scan_valid", scan_valid, e_sv);
            chk("scan_rdata", scan_rdata, e_srd);
            chk("g_rvalid",   g_rvalid,   e_gv);
            chk("g_rdata",    g_rdata,    e_grd);
            chk("clear_busy", clear_busy, e_busy);
            chk("clear_done", clear_done, e_done);
        end
        if (clear_busy) busy_cnt++;
        if (clear_done) done_cnt++;
        clr = i_clr; vblank = i_vb; scan_req = i_sreq; scan_addr = 8'(i_sa);
        g_req = i_greq; g_we = i_gwe; g_addr = 8'(i_ga); g_wdata = 3'(i_gwd);
        clear_start = i_cs;
        #1;
        g = !i_clr && i_greq && !i_sreq && !m_clear && (!i_gwe || i_vb);
        chk("g_gnt", g_gnt, g);
        if (i_clr) begin
            have_exp = 1;
            e_sv = 0; e_gv = 0; e_srd = 0; e_grd = 0; e_busy = 0; e_done = 0;
            m_clear = 0; m_cidx = 0;
        end else if (have_exp) begin
            e_done = 0;
            e_sv = i_sreq;
            if (i_sreq) e_srd = rd(i_sa);
            e_gv = g && !i_gwe;
            if (e_gv) e_grd = rd(i_ga);
            if (g && i_gwe && i_ga < 200) mem_m[i_ga] = i_gwd;
            if (m_clear) begin
                if (!i_sreq && i_vb) begin
                    mem_m[m_cidx] = 0;
                    if (m_cidx == 199) begin
                        m_clear = 0; m_cidx = 0; e_done = 1;
                    end else m_cidx++;
                end
            end else if (i_cs) m_clear = 1;
            e_busy = m_clear;
        end
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill7();
        for (int i = 0; i < 200; i++) cyc(0, 1, 0, 0, 1, 1, i, 7, 0);
    endtask

    task automatic scan_all();
        for (int i = 0; i < 200; i++) cyc(0, 0, 1, i, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        clr = 1; vblank = 0; scan_req = 0; g_req = 0; g_we = 0; clear_start = 0;
        scan_addr = 0; g_addr = 0; g_wdata = 0;
        // reset, with a pending game request that must not be granted
        cyc(1, 1, 0, 0, 1, 1, 3, 2, 0);
        cyc(1, 1, 0, 0, 1, 0, 3, 0, 0);
        idle();
        fill7();

        // scanout priority over a game read of address 5
        cyc(0, 1, 1, 12, 1, 0, 5, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 5, 0, 0);
        idle();
        // write 37 = 5 then scan-read it
        cyc(0, 1, 0, 0, 1, 1, 37, 5, 0);
        cyc(0, 1, 1, 37, 0, 0, 0, 0, 0);
        idle();
        // vblank gating of game writes, reads still pass
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 44, 3, 0);
        cyc(0, 1, 0, 0, 1, 1, 44, 3, 0);
        cyc(0, 0, 0, 0, 1, 0, 44, 0, 0);
        // out-of-range write granted but dropped, read returns 0
        cyc(0, 1, 0, 0, 1, 1, 230, 6, 0);
        cyc(0, 0, 0, 0, 1, 0, 230, 0, 0);
        cyc(0, 0, 1, 255, 0, 0, 0, 0, 0);
        idle();

        // full clear, unstalled; start coincides with a granted game write
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 0, 0, 1, 1, 9, 4, 1);
        for (int k = 0; k < 1000 && m_clear; k++) cyc(0, 1, 0, 0, 1, 0, 8, 0, 1);
        idle();
        chk("clear_len", busy_cnt, 200);
        chk("done_pulses", done_cnt, 1);
        scan_all();

        // stalled clear: 10 scanout cycles mid-clear
        fill7();
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 1000 && m_clear; k++)
            cyc(0, 1, (k >= 50 && k < 60), $urandom_range(0, 199), 0, 0, 0, 0, 0);
        idle();
        chk("stall_len", busy_cnt, 210);
        chk("stall_done", done_cnt, 1);

        // reset at clear count 50
        fill7();
        busy_cnt = 0; done_cnt = 0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 1000 && m_cidx < 50; k++) idle();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("abort_done", done_cnt, 0);
        chk("abort_idx", m_cidx, 0);
        scan_all();

        // randomized traffic
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
                $urandom_range(0, 7), $urandom_range(0, 299) == 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
